char_ram_writer: RTL and testbench
==================================

// Module: char_ram_writer
// PURPOSE
//   Write port for the labyrinth character RAM, which the VGA path reads (wea is tied low today).
//   Latches a room number and then either clears that room's 4x64 text page or streams an ASCII phrase into it.
//   Phrase characters arrive over a valid/ready handshake.
//   Drives wea/addra/dina directly, with the same address packing as the read side: {room, row, col}.
// PARAMETERS
//   ROOM_W     8      room-number width (upper address field)
//   ROW_W      2      text-row field width (4 rows per room)
//   COL_W      6      text-column field width (64 columns per row)
//   DATA_W     8      character width (ASCII)
//   FILL_CHAR  8'h20  value written by a clear, and by a backspace when enabled
// PORTS
//   clk_50MHz_i    in   1                    system clock, 50 MHz
//   rst_sync_ha_i  in   1                    synchronous reset, active-high
//   room_i         in   ROOM_W               target room; sampled on an accepted clear_i/open_i
//   clear_i        in   1                    request fill of the whole room page with FILL_CHAR
//   open_i         in   1                    request a phrase write starting at row 0, col 0
//   char_i         in   DATA_W               phrase character
//   char_valid_i   in   1                    char_i valid
//   char_ready_o   out  1                    writer accepts char_i this cycle
//   we_o           out  1                    RAM write enable (to wea)
//   addr_o         out  ROOM_W+ROW_W+COL_W   RAM address {room, row, col}
//   din_o          out  DATA_W               RAM write data
//   busy_o         out  1                    high in every state except IDLE
//   overflow_o     out  1                    sticky; phrase ran past row 3 col 63
//   done_o         out  1                    one-cycle pulse when a clear or phrase completes
// BEHAVIOUR
//   Reset (sync, any state, mid-operation included):
//     - FSM goes to IDLE; cursor, room and pending-open cleared; no write in the reset cycle.
//     - All outputs read 0 on the first cycle after reset.
//   States: IDLE, CLEARING, PHRASE, FINISH.
//   IDLE:
//     - clear_i: latch room_i, cursor=0, go to CLEARING.
//     - open_i alone: latch room_i, cursor=0, clear overflow_o, go to PHRASE.
//     - clear_i & open_i in the same cycle: clear runs first, open is recorded as pending,
//       and overflow_o is cleared.
//   Outside IDLE, clear_i and open_i are ignored (not queued).
//   CLEARING:
//     - One write per cycle: we_o=1, din_o=FILL_CHAR, addr_o={room,cursor}; cursor += 1.
//     - Exactly 2^(ROW_W+COL_W)=256 writes.
//     - When the cursor wraps to 0, go to PHRASE if an open is pending (cursor=0), else go to FINISH.
//   PHRASE:
//     - char_ready_o=1. A character is accepted when char_valid_i & char_ready_o.
//     - 0x00: end of phrase; no write; go to FINISH.
//     - 0x0A: col=0, row+=1; no write.
//     - Any other value: write it at the cursor, then col+=1; col 63 wraps to col 0 of row+1.
//     - Row increment past row 3 sets a full flag. While full, characters are accepted and
//       dropped (no write) and overflow_o=1, until 0x00 arrives. Ready stays high to drain the source.
//   FINISH: done_o=1 for exactly one cycle, then IDLE.
//   Timing:
//     - we_o/addr_o/din_o are registered: the write appears on the cycle after acceptance.
//     - Sustained throughput is 1 character per cycle.
//     - Back-to-back requests: from done_o, the earliest new request is accepted the following
//       cycle, in IDLE.
//   we_o=0 whenever no write is issued; addr_o and din_o hold their last values.
//   overflow_o is cleared only by reset or by an accepted open_i.
// CONFIGURATION
//   CHAR_RAM_WRITER_BACKSPACE_EN defined: in PHRASE, 0x08 moves the cursor back one cell and writes FILL_CHAR there.
//     - At col 0 with row>0, the cursor moves to col 63 of row-1.
//     - At row 0 col 0 there is no write and no move.
//     - When full, 0x08 clears the full flag, the cursor returns to row 3 col 63, and that cell is blanked.
//     - overflow_o remains set.
//   CHAR_RAM_WRITER_BACKSPACE_EN undefined: 0x08 is treated as an ordinary printable character.
// TESTING
//   1. Clear: room_i=8'h05, clear_i pulse
//      -> 256 consecutive writes with din=8'h20, addr 16'h0500..16'h05FF, then done_o one cycle later.
//   2. Phrase: open room 8'h02, stream "HI",0x0A,"A",0x00 with valid held high
//      -> writes 16'h0200='H', 16'h0201='I', 16'h0240='A'; then done_o; overflow_o=0.
//   3. Wrap and overflow: open room 0, send 257 chars 'x' then 0x00
//      -> 256 writes 16'h0000..16'h00FF; 257th not written; overflow_o=1; done_o.
//   4. Simultaneous: clear_i & open_i with room 8'h07, then "Z",0x00
//      -> 256 fills, then a write of 'Z' at 16'h0700; a single done_o at the end.
//   5. Reset mid-clear: assert rst_sync_ha_i after 10 clear writes
//      -> next cycle: we_o=0, busy_o=0, done_o=0; clear_i/open_i during busy ignored (checked before reset).
//   6. Backspace (macro on): open room 1, send "AB",0x08,0x00
//      -> writes 16'h0100='A', 16'h0101='B', 16'h0101=8'h20; macro off -> 16'h0102=8'h08.

Source files
------------

// File: rtl/char_ram_writer_if.sv
// ---------------------------------------------------------------------------
// char_ram_writer_if
//   Bundles the phrase-character handshake and the character-RAM write bus
//   used by char_ram_writer.
//
//   Signals
//     char_data   phrase character (writer input, char_i)
//     char_valid  char_data valid (writer input, char_valid_i)
//     char_ready  writer accepts char_data this cycle (writer output, char_ready_o)
//     we          RAM write enable, drives wea (writer output, we_o)
//     addr        RAM address {room, row, col}, drives addra (writer output, addr_o)
//     din         RAM write data, drives dina (writer output, din_o)
//
//   Modports
//     master  character source / RAM side (testbench, upstream logic)
//     slave   char_ram_writer
//
//   Parameters must match those of the char_ram_writer instance it connects to.
// ---------------------------------------------------------------------------
interface char_ram_writer_if #(
    parameter int unsigned ROOM_W = 8,
    parameter int unsigned ROW_W  = 2,
    parameter int unsigned COL_W  = 6,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned ADDR_W = ROOM_W + ROW_W + COL_W;

    logic [DATA_W-1:0] char_data;
    logic              char_valid;
    logic              char_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;

    modport master (
        output char_data,
        output char_valid,
        input  char_ready,
        input  we,
        input  addr,
        input  din
    );

    modport slave (
        input  char_data,
        input  char_valid,
        output char_ready,
        output we,
        output addr,
        output din
    );
endinterface

// File: rtl/char_ram_writer.sv
// ---------------------------------------------------------------------------
// char_ram_writer
//   Write port for the labyrinth character RAM. Latches a room number and then
//   either fills that room's 4x64 text page with FILL_CHAR or streams an ASCII
//   phrase into it, starting at row 0 col 0. RAM address packing matches the
//   VGA read side: {room, row, col}.
//
//   Ports
//     clk_50MHz_i    system clock, 50 MHz
//     rst_sync_ha_i  synchronous reset, active-high
//     room_i         target room, sampled on an accepted clear_i/open_i
//     clear_i        request fill of the whole room page with FILL_CHAR
//     open_i         request a phrase write starting at row 0, col 0
//     bus_io         char_ram_writer_if.slave: char handshake in, RAM write bus out
//     busy_o         high in every state except idle
//     overflow_o     sticky; phrase ran past row 3 col 63 (cleared by reset/open)
//     done_o         one-cycle pulse when a clear or phrase completes
//
//   Build option
//     CHAR_RAM_WRITER_BACKSPACE_EN  when defined, 0x08 in a phrase erases the
//                                   previous cell; otherwise 0x08 is printable.
// ---------------------------------------------------------------------------
module char_ram_writer #(
    parameter int unsigned       ROOM_W    = 8,
    parameter int unsigned       ROW_W     = 2,
    parameter int unsigned       COL_W     = 6,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              clk_50MHz_i,
    input  logic              rst_sync_ha_i,
    input  logic [ROOM_W-1:0] room_i,
    input  logic              clear_i,
    input  logic              open_i,
    char_ram_writer_if.slave  bus_io,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              done_o
);
    localparam int unsigned CUR_W  = ROW_W + COL_W;
    localparam int unsigned ADDR_W = ROOM_W + CUR_W;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StClearing = 2'd1;
    localparam logic [1:0] StPhrase   = 2'd2;
    localparam logic [1:0] StFinish   = 2'd3;

    localparam logic [CUR_W-1:0]  CurMax = '1;
    localparam logic [ROW_W-1:0]  RowMax = '1;
    localparam logic [DATA_W-1:0] ChNul  = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] ChLf   = DATA_W'(8'h0A);
`ifdef CHAR_RAM_WRITER_BACKSPACE_EN
    localparam logic [DATA_W-1:0] ChBs   = DATA_W'(8'h08);
`endif

    logic [1:0]        state_q, state_d;
    logic [ROOM_W-1:0] room_q, room_d;
    logic [CUR_W-1:0]  cursor_q, cursor_d;   // {row, col}
    logic              pend_q, pend_d;       // open requested together with clear
    logic              full_q, full_d;       // phrase has run off the page
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic [ROW_W-1:0]  row;
    logic              accept;

    assign row    = cursor_q[CUR_W-1:COL_W];
    assign accept = (state_q == StPhrase) && bus_io.char_valid;

    always_comb begin
        state_d  = state_q;
        room_d   = room_q;
        cursor_d = cursor_q;
        pend_d   = pend_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;

        case (state_q)
            StIdle: begin
                if (clear_i) begin
                    // Write-ahead: cell 0 is issued now so that each clearing
                    // cycle shows exactly one write at {room, cursor_q}.
                    room_d   = room_i;
                    cursor_d = '0;
                    state_d  = StClearing;
                    we_d     = 1'b1;
                    addr_d   = {room_i, {CUR_W{1'b0}}};
                    din_d    = FILL_CHAR;
                    if (open_i) begin
                        pend_d = 1'b1;
                        ovf_d  = 1'b0;
                    end
                end else if (open_i) begin
                    room_d   = room_i;
                    cursor_d = '0;
                    full_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StPhrase;
                end
            end

            StClearing: begin
                if (cursor_q == CurMax) begin
                    cursor_d = '0;
                    pend_d   = 1'b0;
                    if (pend_q) begin
                        full_d  = 1'b0;
                        state_d = StPhrase;
                    end else begin
                        state_d = StFinish;
                    end
                end else begin
                    cursor_d = cursor_q + CUR_W'(1);
                    we_d     = 1'b1;
                    addr_d   = {room_q, cursor_q + CUR_W'(1)};
                    din_d    = FILL_CHAR;
                end
            end

            StPhrase: begin
                if (accept) begin
                    if (bus_io.char_data == ChNul) begin
                        state_d = StFinish;
`ifdef CHAR_RAM_WRITER_BACKSPACE_EN
                    end else if (bus_io.char_data == ChBs) begin
                        if (full_q) begin
                            // Step back onto the last cell of the page.
                            full_d   = 1'b0;
                            cursor_d = CurMax;
                            we_d     = 1'b1;
                            addr_d   = {room_q, CurMax};
                            din_d    = FILL_CHAR;
                        end else if (cursor_q != '0) begin
                            // col 0 -> col 63 of the previous row falls out
                            // of the packed {row, col} decrement.
                            cursor_d = cursor_q - CUR_W'(1);
                            we_d     = 1'b1;
                            addr_d   = {room_q, cursor_q - CUR_W'(1)};
                            din_d    = FILL_CHAR;
                        end
`endif
                    end else if (full_q) begin
                        // Drain the source without writing.
                    end else if (bus_io.char_data == ChLf) begin
                        if (row == RowMax) begin
                            full_d   = 1'b1;
                            ovf_d    = 1'b1;
                            cursor_d = '0;
                        end else begin
                            cursor_d = {row + ROW_W'(1), {COL_W{1'b0}}};
                        end
                    end else begin
                        we_d     = 1'b1;
                        addr_d   = {room_q, cursor_q};
                        din_d    = bus_io.char_data;
                        cursor_d = cursor_q + CUR_W'(1);
                        if (cursor_q == CurMax) begin
                            full_d = 1'b1;
                            ovf_d  = 1'b1;
                        end
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i) begin
            state_q  <= StIdle;
            room_q   <= '0;
            cursor_q <= '0;
            pend_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            room_q   <= room_d;
            cursor_q <= cursor_d;
            pend_q   <= pend_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign bus_io.char_ready = (state_q == StPhrase);
    assign bus_io.we         = we_q;
    assign bus_io.addr       = addr_q;
    assign bus_io.din        = din_q;

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StFinish);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_char_ram_writer.sv
module tb_char_ram_writer;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic       clk_50MHz;
    logic       rst;
    logic [7:0] room;
    logic       clear;
    logic       open;
    logic       busy;
    logic       overflow;
    logic       done;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int unsigned wr_cnt    = 0;
    int unsigned done_cnt  = 0;
    wr_t         exp_q[$];

    char_ram_writer_if bus ();

    char_ram_writer dut (
        .clk_50MHz_i  (clk_50MHz),
        .rst_sync_ha_i(rst),
        .room_i       (room),
        .clear_i      (clear),
        .open_i       (open),
        .bus_io       (bus),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .done_o       (done)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Advance one clock, sample 1 ns later, score any RAM write.
    task automatic tick();
        wr_t e;
        @(posedge clk_50MHz);
        #1;
        if (bus.we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(bus.we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.addr), 32'(e.addr));
                chk("wr_data", 32'(bus.din), 32'(e.data));
            end
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("we_at_done", 32'(bus.we), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.char_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("ready_seen", 32'(bus.char_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] c);
        bus.char_data  = c;
        bus.char_valid = 1'b1;
        tick();
    endtask

    task automatic start(input logic [7:0] r, input logic c, input logic o);
        room  = r;
        clear = c;
        open  = o;
        tick();
        clear = 1'b0;
        open  = 1'b0;
    endtask

    initial begin
        int base;
        rst            = 1'b1;
        room           = '0;
        clear          = 1'b0;
        open           = 1'b0;
        bus.char_data  = '0;
        bus.char_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_din", 32'(bus.din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(bus.char_ready), 32'd0);
        rst = 1'b0;
        tick();

        // 1: clear room 5
        for (int i = 0; i < 256; i++) push(16'h0500 + 16'(i), 8'h20);
        base = wr_cnt;
        start(8'h05, 1'b1, 1'b0);
        chk("clr_busy", 32'(busy), 32'd1);
        wait_done(300);
        chk("clr_count", 32'(wr_cnt - base), 32'd256);

        // 2: phrase "HI\nA" into room 2
        push(16'h0200, "H");
        push(16'h0201, "I");
        push(16'h0240, "A");
        start(8'h02, 1'b0, 1'b1);
        chk("ph_ready", 32'(bus.char_ready), 32'd1);
        send("H");
        send("I");
        send(8'h0A);
        send("A");
        send(8'h00);
        bus.char_valid = 1'b0;
        wait_done(10);
        chk("ph_ovf", 32'(overflow), 32'd0);

        // 3: page wrap and overflow in room 0
        for (int i = 0; i < 256; i++) push(16'h0000 + 16'(i), "x");
        base = wr_cnt;
        start(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 257; i++) send("x");
        chk("ovf_ready_full", 32'(bus.char_ready), 32'd1);
        send(8'h00);
        bus.char_valid = 1'b0;
        wait_done(10);
        chk("ovf_count", 32'(wr_cnt - base), 32'd256);
        chk("ovf_set", 32'(overflow), 32'd1);

        // 4: simultaneous clear+open in room 7
        for (int i = 0; i < 256; i++) push(16'h0700 + 16'(i), 8'h20);
        push(16'h0700, "Z");
        base = int'(done_cnt);
        start(8'h07, 1'b1, 1'b1);
        chk("sim_ovf_clr", 32'(overflow), 32'd0);
        wait_ready(300);
        chk("sim_no_early_done", 32'(done_cnt - base), 32'd0);
        send("Z");
        send(8'h00);
        bus.char_valid = 1'b0;
        wait_done(10);
        chk("sim_one_done", 32'(done_cnt - base), 32'd1);

        // 5: requests ignored while busy, then reset mid-clear
        for (int i = 0; i < 256; i++) push(16'h0300 + 16'(i), 8'h20);
        base = wr_cnt;
        start(8'h03, 1'b1, 1'b0);
        for (int n = 0; n < 20 && (wr_cnt - base) < 10; n++) tick();
        chk("rm_ten_writes", 32'(wr_cnt - base), 32'd10);
        start(8'h09, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rm_we", 32'(bus.we), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("rm_idle", 32'(busy), 32'd0);
        chk("rm_no_pend_we", 32'(bus.we), 32'd0);

        // 6: 0x08 handling
        push(16'h0100, "A");
        push(16'h0101, "B");
`ifdef CHAR_RAM_WRITER_BACKSPACE_EN
        push(16'h0101, 8'h20);
`else
        push(16'h0102, 8'h08);
`endif
        start(8'h01, 1'b0, 1'b1);
        send("A");
        send("B");
        send(8'h08);
        send(8'h00);
        bus.char_valid = 1'b0;
        wait_done(10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
